// File: rtl/apb_master_mc.sv
// apb_master_mc -- single-outstanding APB4 master with multi-slave decode.
//
// Takes one transfer at a time from the core over a valid/ready handshake,
// decodes a slave index from the address, runs the APB SETUP/ACCESS sequence
// (wait states, strobes, slave error), and returns a one-cycle response.
// Out-of-range slave indices and ACCESS phases that exceed TIMEOUT cycles are
// reported as errors without hanging the bus.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE, out of reset)
//   req_addr/write/wdata/strb request payload
//   rsp_valid/rsp_rdata/rsp_err  one-cycle completion pulse and payload
//   psel/penable/pwrite/paddr/pwdata/pstrb  APB master outputs
//   prdata/pready/pslverr    per-slave APB inputs (slave i at slice i)
module apb_master_mc #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_SLAVES = 8,
  parameter int unsigned SEL_LSB    = 8,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic                         req_write,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_strb,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  output logic [DATA_W/8-1:0]          pstrb,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state, state_next;

  // Captured transfer
  logic [ADDR_W-1:0]     addr_q;
  logic                  write_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic [NUM_SLAVES-1:0] sel_q;

  // Request decode
  logic [SEL_W-1:0]      req_idx;
  logic [NUM_SLAVES-1:0] req_sel;
  logic                  dec_err;
  logic                  accept;

  // Selected-slave response
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_W-1:0]     sel_rdata;

  // ACCESS cycle counter
  logic [CNT_W-1:0]      cnt_q;
  logic                  to_hit;

  // Response next-values
  logic                  rsp_valid_d;
  logic                  rsp_err_d;
  logic [DATA_W-1:0]     rsp_rdata_d;

  logic                  active;

  assign req_ready = (state == IDLE) && rst;
  assign accept    = req_valid && req_ready;
  assign req_idx   = req_addr[SEL_LSB +: SEL_W];

  always_comb begin
    dec_err = (32'(req_idx) >= NUM_SLAVES);
    req_sel = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      req_sel[i] = (32'(req_idx) == i);
    end
  end

  // Only the captured slave's handshake lines are looked at; others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // cnt_q holds the index of the current ACCESS cycle (0-based); aborting when
  // it reaches TIMEOUT-1 caps ACCESS at exactly TIMEOUT cycles.
  assign to_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (dec_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_next = SETUP;
          end
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_next  = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = (!write_q && !sel_err) ? sel_rdata : '0;
        end else if (to_hit) begin
          state_next  = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      sel_q   <= '0;
    end else if (accept && !dec_err) begin
      addr_q  <= req_addr;
      write_q <= req_write;
      wdata_q <= req_write ? req_wdata : '0;
      strb_q  <= req_write ? req_strb : '0;
      sel_q   <= req_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state != ACCESS) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  // APB outputs are gated by state so reset clears them in the same cycle.
  assign active  = (state == SETUP) || (state == ACCESS);
  assign psel    = active ? sel_q : '0;
  assign penable = (state == ACCESS);
  assign pwrite  = active && write_q;
  assign paddr   = active ? addr_q : '0;
  assign pwdata  = active ? wdata_q : '0;
  assign pstrb   = active ? strb_q : '0;

endmodule
